// File: rtl/video_stream_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | video_stream_pkg : shared types and constants for RGB video stream blocks  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package video_stream_pkg;

   localparam int PIXELS_PER_GROUP = 4;
   localparam int WORDS_PER_GROUP  = 3;

   typedef logic [7:0] byte_t;

   typedef enum logic [1:0] {
      P0 = 2'd0,
      P1 = 2'd1,
      P2 = 2'd2,
      P3 = 2'd3
   } phase_t;

   // Byte b0 lands in the least significant position of the stream word.
   function automatic logic [31:0] pack_word(input byte_t b0, input byte_t b1,
                                             input byte_t b2, input byte_t b3);
      return {b3, b2, b1, b0};
   endfunction

endpackage
`default_nettype wire

// File: rtl/video_coord_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | video_coord_counter : x/y pixel position tracker with resync to (0,0)      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module video_coord_counter #(
   parameter int X_SIZE = 640,
   parameter int Y_SIZE = 480
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_inc,
   input  logic i_resync,
   output logic o_origin,
   output logic o_x_wrap
);

   localparam int c_xw = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
   localparam int c_yw = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;

   logic [c_xw-1:0] r_x;
   logic [c_yw-1:0] r_y;
   logic            w_y_wrap;

   assign o_x_wrap = (r_x == c_xw'(X_SIZE - 1));
   assign w_y_wrap = (r_y == c_yw'(Y_SIZE - 1));
   assign o_origin = (r_x == '0) && (r_y == '0);

   // A resync pixel is pixel (0,0), so the count continues from (1,0).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x <= '0;
         r_y <= '0;
      end else if (i_inc) begin
         if (i_resync) begin
            r_x <= c_xw'(1);
            r_y <= '0;
         end else if (o_x_wrap) begin
            r_x <= '0;
            r_y <= w_y_wrap ? '0 : r_y + 1'b1;
         end else begin
            r_x <= r_x + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/video_stream_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | video_stream_packer : packs 24-bit RGB pixels into 32-bit AXI-Stream words |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module video_stream_packer
   import video_stream_pkg::*;
#(
   parameter int X_SIZE = 640,
   parameter int Y_SIZE = 480
) (
   input  logic        out_stream_aclk,
   input  logic        axi_resetn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_r,
   input  logic [7:0]  in_g,
   input  logic [7:0]  in_b,
   input  logic        in_sof,
   output logic [31:0] out_stream_tdata,
   output logic [3:0]  out_stream_tkeep,
   output logic        out_stream_tvalid,
   input  logic        out_stream_tready,
   output logic        out_stream_tuser,
   output logic        out_stream_tlast,
   output logic        sof_err
);

   generate
      if ((X_SIZE % PIXELS_PER_GROUP) != 0) begin : g_bad_x_size
         $error("X_SIZE must be a multiple of PIXELS_PER_GROUP");
      end
   endgenerate

   phase_t      r_phase, w_phase_nxt;
   byte_t       r_b0, r_b1, r_b2;
   logic        r_grp_sof;
   logic [31:0] r_tdata;
   logic        r_tvalid, r_tuser, r_tlast, r_sof_err;

   logic        w_accept, w_resync, w_origin, w_x_wrap;
   logic        w_emit, w_user, w_last;
   logic [31:0] w_word;

   assign in_ready = (r_phase == P0) || !r_tvalid || out_stream_tready;
   assign w_accept = in_valid && in_ready;
   assign w_resync = w_accept && in_sof && !(w_origin && (r_phase == P0));

   video_coord_counter #(
      .X_SIZE (X_SIZE),
      .Y_SIZE (Y_SIZE)
   ) u_coord (
      .clk      (out_stream_aclk),
      .rst_n    (axi_resetn),
      .i_inc    (w_accept),
      .i_resync (w_resync),
      .o_origin (w_origin),
      .o_x_wrap (w_x_wrap)
   );

   always_ff @(posedge out_stream_aclk or negedge axi_resetn) begin
      if (!axi_resetn) r_phase <= P0;
      else             r_phase <= w_phase_nxt;
   end

   always_comb begin
      w_phase_nxt = r_phase;
      w_emit      = 1'b0;
      w_word      = '0;
      w_user      = 1'b0;
      w_last      = 1'b0;
      if (w_accept) begin
         if (w_resync) begin
            w_phase_nxt = P1;
         end else begin
            unique case (r_phase)
               P0: w_phase_nxt = P1;
               P1: begin
                  w_phase_nxt = P2;
                  w_emit      = 1'b1;
                  w_word      = pack_word(r_b0, r_b1, r_b2, in_r);
                  w_user      = r_grp_sof;
               end
               P2: begin
                  w_phase_nxt = P3;
                  w_emit      = 1'b1;
                  w_word      = pack_word(r_b0, r_b1, in_r, in_g);
               end
               P3: begin
                  w_phase_nxt = P0;
                  w_emit      = 1'b1;
                  w_word      = pack_word(r_b0, in_r, in_g, in_b);
                  w_last      = w_x_wrap;
               end
               default: w_phase_nxt = P0;
            endcase
         end
      end
   end

   // Leftover bytes are kept low-aligned in r_b0.. so each word reads them in order.
   always_ff @(posedge out_stream_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         r_b0      <= '0;
         r_b1      <= '0;
         r_b2      <= '0;
         r_grp_sof <= 1'b0;
         r_tdata   <= '0;
         r_tvalid  <= 1'b0;
         r_tuser   <= 1'b0;
         r_tlast   <= 1'b0;
         r_sof_err <= 1'b0;
      end else begin
         r_sof_err <= w_resync;
         if (w_accept) begin
            if (w_resync || (r_phase == P0)) begin
               r_b0      <= in_r;
               r_b1      <= in_g;
               r_b2      <= in_b;
               r_grp_sof <= w_resync || w_origin;
            end else if (r_phase == P1) begin
               r_b0 <= in_g;
               r_b1 <= in_b;
            end else if (r_phase == P2) begin
               r_b0 <= in_b;
            end
         end
         if (w_emit) begin
            r_tdata  <= w_word;
            r_tvalid <= 1'b1;
            r_tuser  <= w_user;
            r_tlast  <= w_last;
         end else if (out_stream_tready) begin
            r_tvalid <= 1'b0;
         end
      end
   end

   assign out_stream_tdata  = r_tdata;
   assign out_stream_tkeep  = 4'hF;
   assign out_stream_tvalid = r_tvalid;
   assign out_stream_tuser  = r_tuser;
   assign out_stream_tlast  = r_tlast;
   assign sof_err           = r_sof_err;

endmodule
`default_nettype wire

// File: tb/tb_video_stream_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_video_stream_packer : self-checking bench for video_stream_packer       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_video_stream_packer;

   localparam int X = 8;
   localparam int Y = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_r = '0, in_g = '0, in_b = '0;
   logic        in_sof = 1'b0;
   logic [31:0] tdata;
   logic [3:0]  tkeep;
   logic        tvalid;
   logic        tready = 1'b1;
   logic        tuser, tlast, sof_err;

   always #5 clk = ~clk;

   video_stream_packer #(.X_SIZE(X), .Y_SIZE(Y)) dut (
      .out_stream_aclk   (clk),
      .axi_resetn        (rst_n),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_r              (in_r),
      .in_g              (in_g),
      .in_b              (in_b),
      .in_sof            (in_sof),
      .out_stream_tdata  (tdata),
      .out_stream_tkeep  (tkeep),
      .out_stream_tvalid (tvalid),
      .out_stream_tready (tready),
      .out_stream_tuser  (tuser),
      .out_stream_tlast  (tlast),
      .sof_err           (sof_err)
   );

   typedef struct packed {
      logic [31:0] d;
      logic        u;
      logic        l;
   } exp_t;

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Model: frame position, bytes of the current 4-pixel group, expected word queue.
   int          pix = 0;
   logic [7:0]  grp [12];
   int          gcount = 0;
   bit          gsof = 0;
   exp_t        exq [$];
   logic [31:0] log_d [$];
   bit          log_u [$];
   bit          log_l [$];
   bit          exp_sof_err = 0;
   bit          exp_valid_next = 0;
   bit          prev_stall = 0;
   logic [31:0] prev_d;
   bit          prev_u, prev_l;
   int          sof_cnt = 0;
   int          tr_mode = 0;

   task automatic model_accept(input logic [7:0] r, input logic [7:0] g,
                               input logic [7:0] b, input logic sof);
      int   k;
      exp_t e;
      if (sof && pix != 0) begin
         pix         = 0;
         gcount      = 0;
         exp_sof_err = 1;
      end
      if (gcount == 0) gsof = (pix == 0);
      grp[gcount*3]     = r;
      grp[gcount*3 + 1] = g;
      grp[gcount*3 + 2] = b;
      gcount++;
      if (gcount >= 2) begin
         k   = gcount - 2;
         e.d = {grp[4*k+3], grp[4*k+2], grp[4*k+1], grp[4*k]};
         e.u = (k == 0) && gsof;
         e.l = (k == 2) && ((pix % X) == X - 1);
         exq.push_back(e);
         exp_valid_next = 1;
      end
      if (gcount == 4) gcount = 0;
      pix = (pix + 1) % (X * Y);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         chk("rst_tvalid", tvalid, 0);
         chk("rst_tdata", tdata, 0);
         chk("rst_tuser", tuser, 0);
         chk("rst_tlast", tlast, 0);
         chk("rst_sof_err", sof_err, 0);
         chk("rst_in_ready", in_ready, 1);
         chk("rst_tkeep", tkeep, 4'hF);
         pix = 0; gcount = 0; exq.delete();
         exp_sof_err = 0; exp_valid_next = 0; prev_stall = 0;
      end else begin
         chk("sof_err", sof_err, exp_sof_err);
         if (sof_err) sof_cnt++;
         exp_sof_err = 0;
         if (exp_valid_next) chk("latency_tvalid", tvalid, 1);
         exp_valid_next = 0;
         if (prev_stall) begin
            chk("stall_tvalid", tvalid, 1);
            chk("stall_tdata", tdata, prev_d);
            chk("stall_tuser", tuser, prev_u);
            chk("stall_tlast", tlast, prev_l);
         end
         chk("in_ready", in_ready, ((pix % 4) == 0) || !tvalid || tready);
         if (tvalid && tready) begin
            if (exq.size() == 0) begin
               chk("unexpected_word", tdata, 32'hxxxxxxxx);
            end else begin
               e = exq.pop_front();
               chk("tdata", tdata, e.d);
               chk("tuser", tuser, e.u);
               chk("tlast", tlast, e.l);
               chk("tkeep", tkeep, 4'hF);
            end
            log_d.push_back(tdata);
            log_u.push_back(tuser);
            log_l.push_back(tlast);
         end
         prev_stall = tvalid && !tready;
         prev_d = tdata; prev_u = tuser; prev_l = tlast;
         if (in_valid && in_ready) model_accept(in_r, in_g, in_b, in_sof);
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (tr_mode == 1) tready = 1'($urandom_range(0, 1));
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_pixel(input logic [7:0] r, input logic [7:0] g,
                             input logic [7:0] b, input logic sof);
      int n = 0;
      bit done = 0;
      in_valid = 1'b1; in_r = r; in_g = g; in_b = b; in_sof = sof;
      while (!done) begin
         @(negedge clk);
         done = in_ready;
         @(posedge clk);
         #1;
         n++;
         if (!done && n > 1000) begin
            checks++;
            $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles", n);
            done = 1;
         end
      end
      in_valid = 1'b0; in_sof = 1'b0;
   endtask

   initial begin
      int base;
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      idle(3);
      rst_n = 1'b1;

      // Two full frames, R=G=B=pixel index; in_sof at (0,0) is benign.
      for (int n = 0; n < 32; n++)
         send_pixel(8'(n), 8'(n), 8'(n), (n == 0) || (n == 16));
      idle(3);
      chk("frames_word_count", log_d.size(), 24);
      chk("w0_literal", log_d[0], 32'h01000000);
      chk("w0_tuser", log_u[0], 1);
      chk("w1_literal", log_d[1], 32'h02020101);
      chk("w2_literal", log_d[2], 32'h03030302);
      chk("w3_literal", log_d[3], 32'h05040404);
      chk("f2_w0_literal", log_d[12], 32'h11101010);
      for (int i = 0; i < 24; i++) begin
         chk("frame_tuser", log_u[i], (i == 0) || (i == 12));
         chk("frame_tlast", log_l[i], (i == 5) || (i == 11) || (i == 17) || (i == 23));
      end
      chk("benign_sof_err", sof_cnt, 0);

      // Random backpressure and input gaps across two frames.
      base = log_d.size();
      tr_mode = 1;
      for (int n = 0; n < 32; n++) begin
         idle($urandom_range(0, 2));
         send_pixel(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      end
      tr_mode = 0;
      idle(1);
      tready = 1'b1;
      idle(4);
      chk("random_word_count", log_d.size() - base, 24);

      // Resync: in_sof on pixel 5 of line 0.
      base = log_d.size();
      sof_cnt = 0;
      for (int n = 0; n < 5; n++) send_pixel(8'(n), 8'(n), 8'(n), 1'b0);
      send_pixel(8'h10, 8'h20, 8'h30, 1'b1);
      for (int n = 0; n < 15; n++) send_pixel(8'(8'h11 + n), 8'(8'h21 + n), 8'(8'h31 + n), 1'b0);
      idle(3);
      chk("resync_sof_err_count", sof_cnt, 1);
      chk("resync_word_count", log_d.size() - base, 15);
      chk("resync_w0_literal", log_d[base+3], 32'h11302010);
      chk("resync_w0_tuser", log_u[base+3], 1);
      chk("resync_tlast", log_l[base+8], 1);

      // Reset mid-frame with a stalled output word.
      for (int n = 0; n < 5; n++) send_pixel(8'(n), 8'(n), 8'(n), 1'b0);
      tready = 1'b0;
      send_pixel(8'h55, 8'h55, 8'h55, 1'b0);
      idle(2);
      chk("stalled_tvalid", tvalid, 1);
      rst_n = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tready = 1'b1;
      base = log_d.size();
      for (int n = 0; n < 4; n++) send_pixel(8'(8'h40 + n), 8'(8'h40 + n), 8'(8'h40 + n), 1'b0);
      idle(3);
      chk("post_reset_word_count", log_d.size() - base, 3);
      chk("post_reset_w0", log_d[base], 32'h41404040);
      chk("post_reset_tuser", log_u[base], 1);

      idle(3);
      chk("drain_queue_empty", exq.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/video_stream_packer.md
VIDEO_STREAM_PACKER -- requirements
Module: video_stream_packer

Interface
REQ-001 SHALL have parameter X_SIZE, default 640, meaning pixels per line; it must be a multiple of 4.
REQ-002 SHALL have parameter Y_SIZE, default 480, meaning lines per frame.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 out_stream_aclk  in  1  sole clock; all logic on its rising edge.
REQ-005 axi_resetn  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  pixel present.
REQ-007 in_ready  out  1  pixel accepted when in_valid && in_ready.
REQ-008 in_r, in_g, in_b  in  8 each  pixel colour bytes.
REQ-009 in_sof  in  1  marks the accepted pixel as pixel (0,0) of a frame.
REQ-010 out_stream_tdata  out  32  packed RGB word.
REQ-011 out_stream_tkeep  out  4  constant 4'hF.
REQ-012 out_stream_tvalid  out  1  word present.
REQ-013 out_stream_tready  in  1  downstream accepts the word.
REQ-014 out_stream_tuser  out  1  SOF: asserted on the first word of a frame.
REQ-015 out_stream_tlast  out  1  EOL: asserted on the last word of a line.
REQ-016 sof_err  out  1  one-cycle pulse on a resynchronising in_sof.

Function
REQ-017 SHALL pack 4 pixels into 3 words, giving X_SIZE*3/4 words per line, with bytes listed LSB to MSB:
- W0={R0,G0,B0,R1}
- W1={G1,B1,R2,G2}
- W2={B2,R3,G3,B3}
REQ-018 SHALL track the group phase with FSM states P0..P3:
- P0: store 3 bytes, emit no word, go to P1.
- P1: emit W0, store G1 and B1, go to P2.
- P2: emit W1, store B2, go to P3.
- P3: emit W2, go to P0.
REQ-019 SHALL set in_ready = (phase==P0) || !out_stream_tvalid || out_stream_tready.
REQ-020 SHALL register each output word so it appears with tvalid=1 on the cycle after the completing pixel is accepted (latency 1).
REQ-021 SHALL hold tdata, tuser and tlast stable while tvalid && !tready.
REQ-022 SHALL clear tvalid on a handshake unless a new word is loaded in the same cycle; back-to-back full throughput (one word per cycle) is required.
REQ-023 SHALL keep pixel counters x (0..X_SIZE-1) and y (0..Y_SIZE-1), advanced on each accepted pixel:
- x wraps to 0 at X_SIZE-1 and y increments.
- y wraps to 0 at Y_SIZE-1.
REQ-024 SHALL assert tuser on the W0 word whose pixel 0 is at (0,0).
REQ-025 SHALL assert tlast on the W2 word containing pixel x=X_SIZE-1.
REQ-026 SHALL handle an in_sof pixel accepted while counters are not at (0,0) with phase P0 as follows:
- Discard any partial bytes.
- Treat the pixel as (0,0), phase P0.
- Pulse sof_err for one cycle.
- Leave any already-registered output word undisturbed.
REQ-027 SHALL ignore in_sof when the counters are already at (0,0) with phase P0; no sof_err.
REQ-028 SHALL ignore in_r, in_g, in_b and in_sof when no input handshake occurs.

Reset
REQ-029 SHALL, on axi_resetn low, immediately set:
- tvalid=0, tuser=0, tlast=0, tdata=0
- sof_err=0
- phase=P0, x=0, y=0
- stored bytes=0
REQ-030 SHALL drive in_ready=1 during and after reset.
REQ-031 SHALL, on reset mid-frame, drop the partial word and all pending output; the first pixel after reset is (0,0).

Structure
REQ-032 SHALL take the following from shared package video_stream_pkg, also used by pixel_generator benches:
- PIXELS_PER_GROUP=4, WORDS_PER_GROUP=3.
- The phase enum (P0..P3).
- The 8-bit byte typedef.
REQ-033 SHALL place the x/y counters in sub-module video_coord_counter, which has increment, resync and wrap outputs.

Verification (X_SIZE=8, Y_SIZE=2 unless stated)
REQ-034 Feed pixels R=G=B=n for n=0..3, tready=1 -> words 0x01000000 (tuser=1), 0x02020101, 0x03030302, one cycle after pixels 1, 2 and 3.
REQ-035 Feed 2 full frames (16 pixels each), tready=1 -> 12 words per frame; tlast on words 6 and 12; tuser on words 1 and 13 only.
REQ-036 Use random tready at 50% -> tdata/tuser/tlast stable while stalled; no lost or duplicated words; in_ready never 1 while phase!=P0 && tvalid && !tready.
REQ-037 Assert in_sof on pixel 5 of line 0 -> sof_err pulses once; next words are W0 with tuser=1 built from that pixel.
REQ-038 Pulse axi_resetn low after 6 pixels -> tvalid=0 immediately; next pixel starts a frame with tuser=1 on its W0.
REQ-039 Use X_SIZE=640, Y_SIZE=480 with tready=1 -> 480 words per line with tlast on each 480th word, 230400 words per frame.
